// File: rtl/prco_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prco_uart_pkg
//  Purpose  : Shared constants for the UART transmit arbiter and serializer.
//  Revision : 1.0  initial release
// ============================================================================
package prco_uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_REQ0 = 2'b01;
    localparam logic [1:0] GRANT_REQ1 = 2'b10;

    // Round-robin pointer value favouring the requester that did not own the packet.
    function automatic logic rr_after(input logic [1:0] owner);
        return (owner == GRANT_REQ0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prco_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : prco_uart_tx_serializer
//  Purpose  : 8N1 serializer; a load strobe in IDLE launches one frame.
//  Revision : 1.0  initial release
// ============================================================================
module prco_uart_tx_serializer
    import prco_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_load,
    input  logic [DATA_BITS-1:0] i_byte,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_MAX  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         c_LAST_BIT  = 3'(DATA_BITS - 1);

    logic [1:0]           r_state;
    logic [c_CNT_W-1:0]   r_baud;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 w_bit_end;

    assign w_bit_end = (r_baud == c_BAUD_MAX);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (i_load) begin
                        r_shift <= i_byte;
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + c_CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == c_LAST_BIT) begin
                            r_bit   <= '0;
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            // Shift first so r_shift[0] always mirrors the bit on the line.
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + c_CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_baud <= r_baud + c_CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_STOP) && w_bit_end;

endmodule
`default_nettype wire

// File: rtl/prco_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : prco_uart_tx_arbiter
//  Purpose  : Round-robin, packet-locked sharing of one UART TX pin by two
//             byte requesters (core output and debug reporter).
//  Revision : 1.0  initial release
// ============================================================================
module prco_uart_tx_arbiter
    import prco_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_byte,
    input  logic       i_req0_last,
    output logic       q_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_byte,
    input  logic       i_req1_last,
    output logic       q_req1_ready,
    output logic       q_tx,
    output logic       q_busy,
    output logic [1:0] q_grant,
    output logic       q_frame_done
);

    logic       r_armed;
    logic       r_lock;
    logic       r_rr;
    logic [1:0] r_grant;

    logic       w_busy;
    logic       w_done;
    logic [1:0] w_pick;
    logic       w_load;
    logic [7:0] w_byte;
    logic       w_last;

    // r_armed holds both readies low while reset is asserted.
    always_comb begin
        w_pick = GRANT_NONE;
        if (i_en && r_armed && !w_busy) begin
            if (r_lock) begin
                if (r_grant == GRANT_REQ0 && i_req0_valid)
                    w_pick = GRANT_REQ0;
                else if (r_grant == GRANT_REQ1 && i_req1_valid)
                    w_pick = GRANT_REQ1;
            end else if (i_req0_valid && i_req1_valid) begin
                w_pick = r_rr ? GRANT_REQ1 : GRANT_REQ0;
            end else if (i_req0_valid) begin
                w_pick = GRANT_REQ0;
            end else if (i_req1_valid) begin
                w_pick = GRANT_REQ1;
            end
        end
    end

    assign w_load = (w_pick != GRANT_NONE);
    assign w_byte = (w_pick == GRANT_REQ1) ? i_req1_byte : i_req0_byte;
    assign w_last = (w_pick == GRANT_REQ1) ? i_req1_last : i_req0_last;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_armed <= 1'b0;
            r_lock  <= 1'b0;
            r_rr    <= 1'b0;
            r_grant <= GRANT_NONE;
        end else begin
            r_armed <= 1'b1;
            if (w_load) begin
                r_grant <= w_pick;
                r_lock  <= !w_last;
            end else if (w_done && !r_lock) begin
                // Packet complete: free the line and favour the other requester.
                r_grant <= GRANT_NONE;
                r_rr    <= rr_after(r_grant);
            end
        end
    end

    prco_uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (w_load),
        .i_byte    (w_byte),
        .o_tx      (q_tx),
        .o_busy    (w_busy),
        .o_done    (w_done)
    );

    assign q_req0_ready = (w_pick == GRANT_REQ0);
    assign q_req1_ready = (w_pick == GRANT_REQ1);
    assign q_busy       = w_busy;
    assign q_grant      = r_grant;
    assign q_frame_done = w_done;

endmodule
`default_nettype wire
